bus_arbiter: RTL



---
 rtl/bus_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-port (fetch F, load/store L) owner arbiter for the single
// system bus master. One owner per transaction; non-owners see a busy bus.

package bus_arbiter_pkg;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY  = 2'b00;
  localparam resp_t RESP_ERROR = 2'b10;
endpackage

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int LSU_PRIORITY = 1
) (
  input  logic        clock,
  input  logic        nreset,
  // fetch port
  input  logic        f_start,
  input  logic [31:0] f_address,
  input  logic        f_write,
  input  logic [31:0] f_write_data,
  output logic        f_available,
  output logic        f_ready,
  output resp_t       f_response,
  output logic [31:0] f_read_data,
  // load/store port
  input  logic        l_start,
  input  logic [31:0] l_address,
  input  logic        l_write,
  input  logic [31:0] l_write_data,
  output logic        l_available,
  output logic        l_ready,
  output resp_t       l_response,
  output logic [31:0] l_read_data,
  // interconnect side
  output logic        bus_start,
  output logic [31:0] bus_address,
  output logic        bus_write,
  output logic [31:0] bus_write_data,
  input  logic        bus_available,
  input  logic        bus_ready,
  input  resp_t       bus_response,
  input  logic [31:0] bus_read_data,
  output logic [1:0]  grant
);

  // State encoding doubles as the one-hot grant, so grant is a pure register.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_F = 2'b01,
    OWN_L = 2'b10
  } state_e;

  localparam bit LPRIO = (LSU_PRIORITY != 0);

  state_e state;
  logic   last_l;  // 1: most recent grant went to L

  // L wins a tie under fixed priority, or under round-robin when F went last.
  logic pick_l;
  assign pick_l = l_start && (!f_start || LPRIO || !last_l);

  // Ownership FSM: grant from IDLE only, release on the owner's first start low.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      last_l <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_l) begin
            state  <= OWN_L;
            last_l <= 1'b1;
          end else if (f_start) begin
            state  <= OWN_F;
            last_l <= 1'b0;
          end
        end
        OWN_F:   if (!f_start) state <= IDLE;
        OWN_L:   if (!l_start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign grant = state;

  // Request mux toward the interconnect: owner's request, zeros when idle.
  always_comb begin
    bus_start      = 1'b0;
    bus_address    = '0;
    bus_write      = 1'b0;
    bus_write_data = '0;
    if (state == OWN_F) begin
      bus_start      = f_start;
      bus_address    = f_address;
      bus_write      = f_write;
      bus_write_data = f_write_data;
    end else if (state == OWN_L) begin
      bus_start      = l_start;
      bus_address    = l_address;
      bus_write      = l_write;
      bus_write_data = l_write_data;
    end
  end

  // Reply routing: owner sees the bus, non-owner sees busy; in IDLE both see
  // available/ready so either can start, but late reply data is dropped.
  always_comb begin
    f_available = 1'b0;
    f_ready     = 1'b0;
    f_response  = RESP_OKAY;
    f_read_data = '0;
    l_available = 1'b0;
    l_ready     = 1'b0;
    l_response  = RESP_OKAY;
    l_read_data = '0;
    unique case (state)
      OWN_F: begin
        f_available = bus_available;
        f_ready     = bus_ready;
        f_response  = bus_response;
        f_read_data = bus_read_data;
      end
      OWN_L: begin
        l_available = bus_available;
        l_ready     = bus_ready;
        l_response  = bus_response;
        l_read_data = bus_read_data;
      end
      default: begin
        f_available = bus_available;
        f_ready     = bus_ready;
        l_available = bus_available;
        l_ready     = bus_ready;
      end
    endcase
  end

endmodule
